// File: rtl/demux_2way_buf.sv
// demux_2way_buf: registered 1:2 demux steering one valid/ready stream to two
// one-entry output buffers, with per-channel delivery counters.
module demux_2way_buf #(
    parameter int WIDTH = 1,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);
    logic [1:0]            v;
    logic [1:0]            rdy;
    logic [1:0]            wr;
    logic [1:0][WIDTH-1:0] d;
    logic [1:0][CNTW-1:0]  c;

    // Readiness looks only at the addressed channel, so a stalled side never blocks the other.
    assign in_ready = ~reset & (sel ? (~v[1] | out1_ready) : (~v[0] | out0_ready));
    assign rdy      = {out1_ready, out0_ready};
    assign wr       = {in_valid & in_ready & sel, in_valid & in_ready & ~sel};

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            d <= '0;
            c <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (wr[n]) d[n] <= in_data;
                v[n] <= wr[n] | (v[n] & ~rdy[n]);
                if (v[n] & rdy[n]) c[n] <= c[n] + 1'b1;
            end
        end
    end

    assign out0_valid = v[0];
    assign out1_valid = v[1];
    assign out0_data  = d[0];
    assign out1_data  = d[1];
    assign cnt0       = c[0];
    assign cnt1       = c[1];
endmodule

// File: tb/tb_demux_2way_buf.sv
// tb_demux_2way_buf: table vectors plus hand sequences, checked against a
// per-channel word queue and delivery counters kept by the bench.
module tb_demux_2way_buf;
    logic       clk = 0;
    logic       reset = 1;
    logic       in_valid = 0;
    logic       in_ready;
    logic [0:0] in_data = 0;
    logic       sel = 0;
    logic       out0_valid, out1_valid;
    logic       out0_ready = 0, out1_ready = 0;
    logic [0:0] out0_data, out1_data;
    logic [7:0] cnt0, cnt1;

    int vectors = 0;
    int miscompares = 0;

    logic       q0[$];
    logic       q1[$];
    logic [7:0] mc0 = 0, mc1 = 0;

    typedef struct {
        bit iv; bit s; bit d; bit r0; bit r1;
        bit e_v0; bit e_v1; bit e_d;
    } vec_t;
    vec_t tbl[5];

    demux_2way_buf #(.WIDTH(1), .CNTW(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state();
        chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
        chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) chk("out0_data", {31'd0, out0_data}, {31'd0, q0[0]});
        if (q1.size() != 0) chk("out1_data", {31'd0, out1_data}, {31'd0, q1[0]});
        chk("cnt0", {24'd0, cnt0}, {24'd0, mc0});
        chk("cnt1", {24'd0, cnt1}, {24'd0, mc1});
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 1; sel = 0; in_data = 1; out0_ready = 1; out1_ready = 1;
        #1;
        chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        q0.delete(); q1.delete(); mc0 = 0; mc1 = 0;
        @(negedge clk);
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out0_data", {31'd0, out0_data}, 32'd0);
        chk("rst_out1_data", {31'd0, out1_data}, 32'd0);
        chk("rst_cnt0", {24'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
        reset = 0; in_valid = 0; out0_ready = 0; out1_ready = 0;
    endtask

    task automatic step(input bit iv, input bit s, input bit d, input bit r0, input bit r1);
        bit ir;
        in_valid = iv; sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        #1;
        ir = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
        chk("in_ready", {31'd0, in_ready}, {31'd0, ir});
        chk_state();
        @(posedge clk);
        if (q0.size() != 0 && r0) begin void'(q0.pop_front()); mc0++; end
        if (q1.size() != 0 && r1) begin void'(q1.pop_front()); mc1++; end
        if (iv && ir) begin
            if (s) q1.push_back(d);
            else q0.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{iv:1, s:0, d:0, r0:1, r1:1, e_v0:1, e_v1:0, e_d:0};
        tbl[1] = '{iv:1, s:1, d:0, r0:1, r1:1, e_v0:0, e_v1:1, e_d:0};
        tbl[2] = '{iv:1, s:0, d:1, r0:1, r1:1, e_v0:1, e_v1:0, e_d:1};
        tbl[3] = '{iv:1, s:1, d:1, r0:1, r1:1, e_v0:0, e_v1:1, e_d:1};
        tbl[4] = '{iv:0, s:0, d:0, r0:1, r1:1, e_v0:0, e_v1:0, e_d:0};

        // Single word held on channel 0, readiness per addressed channel.
        do_reset();
        step(1, 0, 1, 0, 0);
        chk("t1_out0_valid", {31'd0, out0_valid}, 32'd1);
        chk("t1_out0_data", {31'd0, out0_data}, 32'd1);
        chk("t1_out1_valid", {31'd0, out1_valid}, 32'd0);
        in_valid = 0; sel = 0; #1;
        chk("t1_ready_sel0", {31'd0, in_ready}, 32'd0);
        sel = 1; #1;
        chk("t1_ready_sel1", {31'd0, in_ready}, 32'd1);
        sel = 1'bx;
        @(posedge clk); @(negedge clk);
        chk_state();

        // Exhaustive data x sel sweep with both consumers ready.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].iv, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
            chk("sweep_v0", {31'd0, out0_valid}, {31'd0, tbl[i].e_v0});
            chk("sweep_v1", {31'd0, out1_valid}, {31'd0, tbl[i].e_v1});
            if (tbl[i].iv)
                chk("sweep_data", {31'd0, tbl[i].s ? out1_data : out0_data}, {31'd0, tbl[i].e_d});
        end
        chk("sweep_cnt0", {24'd0, cnt0}, 32'd2);
        chk("sweep_cnt1", {24'd0, cnt1}, 32'd2);

        // Stalled channel 1 must not block channel 0 streaming.
        do_reset();
        step(1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("t3_cnt0", {24'd0, cnt0}, 32'd4);
        chk("t3_cnt1", {24'd0, cnt1}, 32'd0);
        chk("t3_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("t3_out1_data", {31'd0, out1_data}, 32'd1);

        // Simultaneous drain and refill of channel 0.
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("t4_out0_valid", {31'd0, out0_valid}, 32'd1);
        chk("t4_out0_data", {31'd0, out0_data}, 32'd1);
        chk("t4_cnt0", {24'd0, cnt0}, 32'd1);

        // Reset with both channels full drops held words.
        do_reset();
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        do_reset();
        step(0, 0, 0, 1, 1);
        chk("t5_cnt0", {24'd0, cnt0}, 32'd0);
        chk("t5_cnt1", {24'd0, cnt1}, 32'd0);

        // Counter wrap after 256 channel-0 transfers.
        do_reset();
        for (int i = 0; i < 255; i++) step(1, 0, i[0], 1, 1);
        step(0, 0, 0, 1, 1);
        chk("t6_cnt0_255", {24'd0, cnt0}, 32'd255);
        step(1, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("t6_cnt0_wrap", {24'd0, cnt0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/demux_2way_buf.md
Name: demux_2way_buf

Overview:
- Registered 1:2 demultiplexer. It is the distribution end of the 2:1 select path: one input stream is steered by `sel` to one of two buffered output channels.
- `sel=0` routes to channel 0 (the "a" side); `sel=1` routes to channel 1 (the "b" side). This matches the mux convention z = c ? b : a.
- Each channel has a one-entry holding register and a valid/ready handshake. Per-channel delivery counters support self-checking benches.

Parameters:
- WIDTH, 1, data width of input and both output channels.
- CNTW, 8, width of per-channel delivery counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word addressed by `sel` this cycle.
- in_data  input  WIDTH  input word.
- sel  input  1  destination channel; sampled only when in_valid=1.
- out0_valid  output  1  channel 0 holds a word.
- out0_ready  input  1  channel 0 consumer accepts.
- out0_data  output  WIDTH  channel 0 word.
- out1_valid  output  1  channel 1 holds a word.
- out1_ready  input  1  channel 1 consumer accepts.
- out1_data  output  WIDTH  channel 1 word.
- cnt0  output  CNTW  completed channel-0 transfers.
- cnt1  output  CNTW  completed channel-1 transfers.

Behaviour:
- Reset is synchronous, active-high, and checked on the rising clk edge.
  - While reset=1: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0, in_ready=0.
  - Reset mid-operation discards any held words; no transfer completes on that edge.
- Per-channel state is two states: EMPTY (valid=0) and FULL (valid=1).
- Input transfer: in_valid & in_ready at a rising edge.
- Output transfer on channel N: outN_valid & outN_ready at a rising edge.
- in_ready is combinational, and with reset=0 equals `~outS_valid | outS_ready`, where S = sel.
  - It depends only on the addressed channel. A stalled channel never blocks traffic to the other.
  - No combinational path from in_valid to in_ready.
- Latency: a word accepted at edge k appears on outS_data with outS_valid=1 immediately after edge k (one cycle). There is no bypass; outputs are always registered.
- Channel N transitions:
  - EMPTY -> FULL on input transfer with sel=N.
  - FULL -> EMPTY on output transfer with no simultaneous input transfer to N.
  - FULL -> FULL on an output transfer plus an input transfer to N at the same edge. outN_data takes the new word, outN_valid stays 1, and cntN increments.
  - FULL with outN_ready=0: outN_data and outN_valid hold stable (no overwrite, since in_ready=0 for that sel).
- An input transfer to one channel and an output transfer on the other channel at the same edge are fully independent.
- The non-addressed channel's data register is never modified.
- Counters:
  - cntN increments by 1 on each channel-N output transfer.
  - Wraps from 2^CNTW-1 to 0 with no flag.
- sel and in_data are don't-care when in_valid=0. X on sel while in_valid=0 must not corrupt state.
- No word is duplicated or dropped. Words to one channel are delivered in acceptance order.

Test Plan:
1. Reset, then in_data=1, sel=0, in_valid=1 for one cycle with out0_ready=0 -> next cycle out0_valid=1, out0_data=1, out1_valid=0, in_ready=0 while sel=0, in_ready=1 while sel=1.
2. Exhaustive sweep of WIDTH=1 in_data∈{0,1} × sel∈{0,1}, both readys=1, one word per cycle -> each word appears on the channel selected by sel one cycle later. Final cnt0=2, cnt1=2. Compare against the reference model out_sel = in_data; the other channel's valid is 0 that cycle.
3. Hold out1_ready=0 with channel 1 full (data 1). Stream 4 words with sel=0, out0_ready=1 -> all 4 delivered on channel 0 back-to-back, cnt0=4. Channel 1 stays valid=1, data=1, cnt1=0.
4. Channel 0 full (data 0), out0_ready=1, and in_valid=1, sel=0, in_data=1 at the same edge -> after the edge out0_valid=1, out0_data=1, cnt0=1, with no bubble.
5. Assert reset for one cycle while both channels are full -> after the edge both valids=0, both data=0, counters=0. The previously held words are never delivered.
6. Drive 256 channel-0 transfers with CNTW=8 -> cnt0 reads 255 after 255 transfers, then 0 after the 256th.
